// File: rtl/program_sequencer_pkg.sv
// Shared constants for the program sequencer and its program-memory load port:
// memory geometry, reset-hold length and the externally visible state codes.
package program_sequencer_pkg;

  localparam int PM_DEPTH        = 1024;
  localparam int PM_AW           = $clog2(PM_DEPTH);
  localparam int PS_RESET_CYCLES = 2;

  // Encodings are visible on the state port, so they must not change
  localparam logic [1:0] ST_RESET_HOLD = 2'd0;
  localparam logic [1:0] ST_RUN        = 2'd1;
  localparam logic [1:0] ST_HALT       = 2'd2;
  localparam logic [1:0] ST_LOAD       = 2'd3;

endpackage

// File: rtl/pm_load_port.sv
// Program-memory load port: accepts loader bytes while the sequencer is in LOAD
// and turns each accepted byte into a registered one-cycle memory write.
module pm_load_port
  import program_sequencer_pkg::*;
#(
  parameter int AW = PM_AW
) (
  input  logic          i_clk,
  input  logic          i_rstN,
  input  logic          i_start,
  input  logic          i_active,
  input  logic          i_valid,
  input  logic [7:0]    i_data,
  input  logic          i_last,
  output logic          o_ready,
  output logic          o_loadDone,
  output logic          o_overflow,
  output logic          o_we,
  output logic [AW-1:0] o_waddr,
  output logic [7:0]    o_wdata
);

  logic [AW-1:0] r_ptr;
  logic          r_we;
  logic [AW-1:0] r_waddr;
  logic [7:0]    r_wdata;
  logic          w_accept;
  logic          w_atEnd;

  assign o_ready    = i_active;
  assign w_accept   = i_valid && i_active;
  assign w_atEnd    = &r_ptr;
  assign o_loadDone = w_accept && (i_last || w_atEnd);
  assign o_overflow = w_accept && !i_last && w_atEnd;

  always_ff @(posedge i_clk or negedge i_rstN) begin
    if (!i_rstN) begin
      r_ptr <= '0;
    end else if (i_start) begin
      r_ptr <= '0;
    end else if (w_accept) begin
      r_ptr <= r_ptr + AW'(1);
    end
  end

  // The final byte is still written even though the FSM leaves LOAD on it
  always_ff @(posedge i_clk or negedge i_rstN) begin
    if (!i_rstN) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= w_accept;
      if (w_accept) begin
        r_waddr <= r_ptr;
        r_wdata <= i_data;
      end
    end
  end

  assign o_we    = r_we;
  assign o_waddr = r_waddr;
  assign o_wdata = r_wdata;

endmodule

// File: rtl/program_sequencer.sv
// Program sequencer: owns the PC and program-memory fetch address, sequences CPU
// reset release and debug halt/step, and lends the memory to the byte loader.
module program_sequencer
  import program_sequencer_pkg::*;
#(
  parameter int AW           = PM_AW,
  parameter int RESET_CYCLES = PS_RESET_CYCLES
) (
  input  logic          clk,
  input  logic          async_reset_n,
  input  logic          jmp,
  input  logic          jmp_nz,
  input  logic [AW-1:0] jmp_addr,
  input  logic          dont_jmp,
  input  logic          halt,
  input  logic          step,
  input  logic          ld_start,
  input  logic          ld_valid,
  input  logic [7:0]    ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  output logic [AW-1:0] pm_addr,
  output logic          pm_we,
  output logic [AW-1:0] pm_waddr,
  output logic [7:0]    pm_wdata,
  output logic          cpu_sync_reset,
  output logic          cpu_en,
  output logic [AW-1:0] pc,
  output logic [1:0]    state,
  output logic          ld_err
);

  localparam int CW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  logic [1:0]    r_state;
  logic [1:0]    w_nextState;
  logic [AW-1:0] r_pc;
  logic [CW-1:0] r_rstCnt;
  logic          r_ldErr;
  logic [AW-1:0] w_seqAddr;
  logic [AW-1:0] w_branchAddr;
  logic [AW-1:0] w_pmAddr;
  logic          w_cpuEn;
  logic          w_syncReset;
  logic          w_pcLoad;
  logic          w_pcClear;
  logic          w_loadActive;
  logic          w_loadDone;
  logic          w_overflow;

  // jmp wins over jmp_nz; the sequential address wraps at the top of memory
  always_comb begin
    w_seqAddr = r_pc + AW'(1);
    if (jmp) begin
      w_branchAddr = jmp_addr;
    end else if (jmp_nz && !dont_jmp) begin
      w_branchAddr = jmp_addr;
    end else begin
      w_branchAddr = w_seqAddr;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_pmAddr    = '0;
    w_cpuEn     = 1'b0;
    w_syncReset = 1'b1;
    w_pcLoad    = 1'b0;
    w_pcClear   = 1'b0;
    case (r_state)
      ST_RESET_HOLD: begin
        w_pcClear = 1'b1;
        if (r_rstCnt == CW'(RESET_CYCLES - 1)) begin
          w_nextState = ST_RUN;
        end
      end
      ST_RUN: begin
        w_syncReset = 1'b0;
        if (halt) begin
          w_pmAddr    = r_pc;
          w_nextState = ST_HALT;
        end else begin
          w_cpuEn  = 1'b1;
          w_pmAddr = w_branchAddr;
          w_pcLoad = 1'b1;
        end
      end
      ST_HALT: begin
        w_syncReset = 1'b0;
        w_pmAddr    = r_pc;
        if (!halt) begin
          w_nextState = ST_RUN;
        end else if (step && !ld_start) begin
          w_cpuEn  = 1'b1;
          w_pmAddr = w_branchAddr;
          w_pcLoad = 1'b1;
        end
      end
      ST_LOAD: begin
        if (w_loadDone) begin
          w_nextState = ST_RESET_HOLD;
        end
      end
      default: begin
        w_nextState = ST_RESET_HOLD;
      end
    endcase
    if (ld_start) begin
      w_nextState = ST_LOAD;
    end
  end

  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      r_state  <= ST_RESET_HOLD;
      r_pc     <= '0;
      r_rstCnt <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_pcClear) begin
        r_pc <= '0;
      end else if (w_pcLoad) begin
        r_pc <= w_pmAddr;
      end
      if (r_state == ST_RESET_HOLD && w_nextState == ST_RESET_HOLD) begin
        r_rstCnt <= r_rstCnt + CW'(1);
      end else begin
        r_rstCnt <= '0;
      end
    end
  end

  // A new load clears the overflow flag even if an overflow beat lands alongside
  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      r_ldErr <= 1'b0;
    end else if (ld_start) begin
      r_ldErr <= 1'b0;
    end else if (w_overflow) begin
      r_ldErr <= 1'b1;
    end
  end

  assign w_loadActive = (r_state == ST_LOAD);

  pm_load_port #(
    .AW (AW)
  ) u_loadPort (
    .i_clk      (clk),
    .i_rstN     (async_reset_n),
    .i_start    (ld_start),
    .i_active   (w_loadActive),
    .i_valid    (ld_valid),
    .i_data     (ld_data),
    .i_last     (ld_last),
    .o_ready    (ld_ready),
    .o_loadDone (w_loadDone),
    .o_overflow (w_overflow),
    .o_we       (pm_we),
    .o_waddr    (pm_waddr),
    .o_wdata    (pm_wdata)
  );

  assign pm_addr        = w_pmAddr;
  assign cpu_en         = w_cpuEn;
  assign cpu_sync_reset = w_syncReset;
  assign pc             = r_pc;
  assign state          = r_state;
  assign ld_err         = r_ldErr;

endmodule

// File: tb/tb_program_sequencer.sv
// Directed plus randomized bench for program_sequencer, checked every cycle
// against a behavioural model of fetch, halt/step, reset hold and loading.
module tb_program_sequencer;

  localparam int AW           = 10;
  localparam int RESET_CYCLES = 2;
  localparam int M_RH         = 0;
  localparam int M_RUN        = 1;
  localparam int M_HALT       = 2;
  localparam int M_LOAD       = 3;

  logic          clk = 1'b0;
  logic          async_reset_n;
  logic          jmp, jmp_nz, dont_jmp, halt, step;
  logic [AW-1:0] jmp_addr;
  logic          ld_start, ld_valid, ld_last;
  logic [7:0]    ld_data;
  logic          ld_ready, pm_we, cpu_sync_reset, cpu_en, ld_err;
  logic [AW-1:0] pm_addr, pm_waddr, pc;
  logic [7:0]    pm_wdata;
  logic [1:0]    state;

  int checks   = 0;
  int failures = 0;

  // Model state
  int mMode, mPc, mHold, mPtr, eWaddr, eWdata, eAddr;
  bit mErr, eWe, eEn, eSr, eReady;

  program_sequencer #(
    .AW           (AW),
    .RESET_CYCLES (RESET_CYCLES)
  ) dut (
    .clk            (clk),
    .async_reset_n  (async_reset_n),
    .jmp            (jmp),
    .jmp_nz         (jmp_nz),
    .jmp_addr       (jmp_addr),
    .dont_jmp       (dont_jmp),
    .halt           (halt),
    .step           (step),
    .ld_start       (ld_start),
    .ld_valid       (ld_valid),
    .ld_data        (ld_data),
    .ld_last        (ld_last),
    .ld_ready       (ld_ready),
    .pm_addr        (pm_addr),
    .pm_we          (pm_we),
    .pm_waddr       (pm_waddr),
    .pm_wdata       (pm_wdata),
    .cpu_sync_reset (cpu_sync_reset),
    .cpu_en         (cpu_en),
    .pc             (pc),
    .state          (state),
    .ld_err         (ld_err)
  );

  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [31:0] obsV, input logic [31:0] expV);
    checks++;
    assert (obsV === expV) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obsV, expV);
    end
  endtask

  task automatic modelReset();
    mMode  = M_RH;
    mPc    = 0;
    mHold  = RESET_CYCLES;
    mPtr   = 0;
    mErr   = 1'b0;
    eWe    = 1'b0;
    eWaddr = 0;
    eWdata = 0;
  endtask

  // Combinational expectations for the current mode and inputs
  task automatic modelComb();
    int target;
    if (jmp || (jmp_nz && !dont_jmp)) target = int'(jmp_addr);
    else target = (mPc + 1) % (1 << AW);
    eAddr  = 0;
    eEn    = 1'b0;
    eSr    = 1'b1;
    eReady = 1'b0;
    case (mMode)
      M_RUN: begin
        eSr = 1'b0;
        if (halt) eAddr = mPc;
        else begin eEn = 1'b1; eAddr = target; end
      end
      M_HALT: begin
        eSr   = 1'b0;
        eAddr = mPc;
        if (halt && step && !ld_start) begin eEn = 1'b1; eAddr = target; end
      end
      M_LOAD: eReady = 1'b1;
      default: ;
    endcase
  endtask

  task automatic modelEdge();
    bit acc;
    int nextMode;
    modelComb();
    acc = (mMode == M_LOAD) && ld_valid;
    eWe = acc;
    if (acc) begin
      eWaddr = mPtr;
      eWdata = int'(ld_data);
    end
    if (mMode == M_RH) mPc = 0;
    else if (eEn) mPc = eAddr;
    nextMode = mMode;
    case (mMode)
      M_RH: begin
        mHold--;
        if (mHold == 0) nextMode = M_RUN;
      end
      M_RUN:   if (halt) nextMode = M_HALT;
      M_HALT:  if (!halt) nextMode = M_RUN;
      M_LOAD:  if (acc && (ld_last || mPtr == (1 << AW) - 1)) nextMode = M_RH;
      default: ;
    endcase
    if (acc && !ld_last && mPtr == (1 << AW) - 1) mErr = 1'b1;
    if (acc) mPtr = (mPtr + 1) % (1 << AW);
    if (ld_start) begin
      nextMode = M_LOAD;
      mPtr     = 0;
      mErr     = 1'b0;
    end
    if (nextMode == M_RH && mMode != M_RH) mHold = RESET_CYCLES;
    mMode = nextMode;
  endtask

  task automatic checkOutput();
    modelComb();
    checkEq("state", 32'(state), mMode);
    checkEq("pm_addr", 32'(pm_addr), eAddr);
    checkEq("cpu_en", 32'(cpu_en), 32'(eEn));
    checkEq("cpu_sync_reset", 32'(cpu_sync_reset), 32'(eSr));
    checkEq("ld_ready", 32'(ld_ready), 32'(eReady));
    checkEq("pc", 32'(pc), mPc);
    checkEq("pm_we", 32'(pm_we), 32'(eWe));
    if (eWe) begin
      checkEq("pm_waddr", 32'(pm_waddr), eWaddr);
      checkEq("pm_wdata", 32'(pm_wdata), eWdata);
    end
    checkEq("ld_err", 32'(ld_err), 32'(mErr));
  endtask

  task automatic checkReset(input string tag);
    checkEq({tag, "_state"}, 32'(state), 0);
    checkEq({tag, "_pc"}, 32'(pc), 0);
    checkEq({tag, "_pm_addr"}, 32'(pm_addr), 0);
    checkEq({tag, "_sync_reset"}, 32'(cpu_sync_reset), 1);
    checkEq({tag, "_cpu_en"}, 32'(cpu_en), 0);
    checkEq({tag, "_ld_ready"}, 32'(ld_ready), 0);
    checkEq({tag, "_pm_we"}, 32'(pm_we), 0);
    checkEq({tag, "_pm_waddr"}, 32'(pm_waddr), 0);
    checkEq({tag, "_pm_wdata"}, 32'(pm_wdata), 0);
    checkEq({tag, "_ld_err"}, 32'(ld_err), 0);
  endtask

  task automatic applyStimulus(input logic iJmp, input logic iJnz, input logic [AW-1:0] iAddr,
                               input logic iDont, input logic iHalt, input logic iStep,
                               input logic iStart, input logic iValid, input logic [7:0] iData,
                               input logic iLast);
    jmp      = iJmp;
    jmp_nz   = iJnz;
    jmp_addr = iAddr;
    dont_jmp = iDont;
    halt     = iHalt;
    step     = iStep;
    ld_start = iStart;
    ld_valid = iValid;
    ld_data  = iData;
    ld_last  = iLast;
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic runCycle(input logic iJmp, input logic iJnz, input logic [AW-1:0] iAddr,
                          input logic iDont, input logic iHalt, input logic iStep);
    applyStimulus(iJmp, iJnz, iAddr, iDont, iHalt, iStep, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic loadCycle(input logic iStart, input logic iValid, input logic [7:0] iData,
                           input logic iLast);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, iStart, iValid, iData, iLast);
  endtask

  task automatic overflowLoad();
    loadCycle(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < (1 << AW); i++) loadCycle(1'b0, 1'b1, 8'($urandom), 1'b0);
    checkEq("ovf_waddr", 32'(pm_waddr), 32'h3FF);
    checkEq("ovf_err", 32'(ld_err), 1);
    checkEq("ovf_state", 32'(state), 0);
  endtask

  initial begin
    int n;
    logic haltLvl;
    jmp = 1'b0; jmp_nz = 1'b0; jmp_addr = '0; dont_jmp = 1'b0; halt = 1'b0; step = 1'b0;
    ld_start = 1'b0; ld_valid = 1'b0; ld_data = 8'h00; ld_last = 1'b0;
    async_reset_n = 1'b1;
    modelReset();
    #1 async_reset_n = 1'b0;
    #1 checkReset("por");
    repeat (2) @(posedge clk);
    #1 async_reset_n = 1'b1;

    // Reset release: two hold cycles, then fetches 1,2,3
    repeat (5) runCycle(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    checkEq("rel_pc", 32'(pc), 32'h003);
    repeat (2) runCycle(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    checkEq("pre_jmp_pc", 32'(pc), 32'h005);

    // Jumps
    runCycle(1'b1, 1'b0, 10'h3A7, 1'b0, 1'b0, 1'b0);
    checkEq("jmp_pc", 32'(pc), 32'h3A7);
    runCycle(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0);
    checkEq("seq_pc", 32'(pc), 32'h3A8);
    runCycle(1'b0, 1'b1, 10'h155, 1'b1, 1'b0, 1'b0);
    checkEq("jnz_supp_pc", 32'(pc), 32'h3A9);
    runCycle(1'b0, 1'b1, 10'h010, 1'b0, 1'b0, 1'b0);
    checkEq("jnz_take_pc", 32'(pc), 32'h010);

    // Wrap
    runCycle(1'b1, 1'b0, 10'h3FE, 1'b0, 1'b0, 1'b0);
    runCycle(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0);
    checkEq("top_pc", 32'(pc), 32'h3FF);
    runCycle(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0);
    checkEq("wrap_pc", 32'(pc), 32'h000);

    // Halt / step
    runCycle(1'b1, 1'b0, 10'h010, 1'b0, 1'b0, 1'b0);
    runCycle(1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 1'b0);
    checkEq("halt_state", 32'(state), 2);
    checkEq("halt_pc", 32'(pc), 32'h010);
    runCycle(1'b1, 1'b0, 10'h200, 1'b0, 1'b1, 1'b0);
    checkEq("halt_jmp_ignored_pc", 32'(pc), 32'h010);
    runCycle(1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 1'b1);
    checkEq("step_pc", 32'(pc), 32'h011);
    runCycle(1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 1'b0);
    runCycle(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b1);
    checkEq("unhalt_state", 32'(state), 1);
    runCycle(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0);
    checkEq("resume_pc", 32'(pc), 32'h012);
    runCycle(1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    checkEq("halt_load_state", 32'(state), 3);
    checkEq("halt_load_sr", 32'(cpu_sync_reset), 1);

    // Directed load of three bytes with idle gaps
    loadCycle(1'b0, 1'b1, 8'h8C, 1'b0);
    checkEq("ld0_we", 32'(pm_we), 1);
    checkEq("ld0_waddr", 32'(pm_waddr), 0);
    checkEq("ld0_wdata", 32'(pm_wdata), 32'h8C);
    loadCycle(1'b0, 1'b0, 8'h00, 1'b0);
    checkEq("ld_gap_we", 32'(pm_we), 0);
    loadCycle(1'b0, 1'b1, 8'hE1, 1'b0);
    checkEq("ld1_waddr", 32'(pm_waddr), 1);
    checkEq("ld1_wdata", 32'(pm_wdata), 32'hE1);
    loadCycle(1'b0, 1'b0, 8'h00, 1'b0);
    loadCycle(1'b0, 1'b1, 8'h42, 1'b1);
    checkEq("ld2_waddr", 32'(pm_waddr), 2);
    checkEq("ld2_wdata", 32'(pm_wdata), 32'h42);
    checkEq("ld_done_state", 32'(state), 0);
    repeat (3) runCycle(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    checkEq("ld_run_pc", 32'(pc), 32'h001);
    checkEq("ld_err_clean", 32'(ld_err), 0);

    // Overflow, extra beats ignored, then a new ld_start clears the flag
    overflowLoad();
    repeat (3) loadCycle(1'b0, 1'b1, 8'($urandom), 1'b0);
    loadCycle(1'b1, 1'b0, 8'h00, 1'b0);
    checkEq("err_cleared", 32'(ld_err), 0);

    // Short randomized load
    n = $urandom_range(3, 8);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 1) == 1) loadCycle(1'b0, 1'b0, 8'h00, 1'b0);
      loadCycle(1'b0, 1'b1, 8'($urandom), (i == n - 1));
    end

    // Randomized run with jumps, halts and steps
    haltLvl = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) haltLvl = ~haltLvl;
      runCycle(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0), AW'($urandom),
               1'($urandom), haltLvl, ($urandom_range(0, 3) == 0));
    end

    // Second overflow, run a little, then drop reset mid-run
    overflowLoad();
    repeat (5) runCycle(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    checkEq("pre_reset_pc", 32'(pc), 32'h003);
    #1 async_reset_n = 1'b0;
    #1 checkReset("midrun");
    modelReset();
    @(posedge clk);
    #1 async_reset_n = 1'b1;
    repeat (5) runCycle(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    checkEq("rerelease_pc", 32'(pc), 32'h003);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
